// File: rtl/square_pkg.sv
// rtl/square_pkg.sv - shared types for the shift-add squarer
package square_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/square_step.sv
// rtl/square_step.sv - one add-then-shift step of the shift-add multiplier
module square_step #(
    parameter int width = 32
) (
    input  logic [width-1:0] acc,
    input  logic [width-1:0] m,
    input  logic [width-1:0] q,
    output logic [width-1:0] acc_next,
    output logic [width-1:0] q_next
);

    logic [width:0] sum;

    // The carry out of the add becomes the new acc MSB, so nothing is lost.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, (q[0] ? m : {width{1'b0}})};
        acc_next = sum[width:1];
        q_next   = {sum[0], q[width-1:1]};
    end

endmodule

// File: rtl/square_seq.sv
// rtl/square_seq.sv - sequential shift-add squarer behind valid/ready handshakes
module square_seq
    import square_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] p_hi,
    output logic [width-1:0] p_lo
);

    localparam int CW = $clog2(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [width-1:0] m;
    logic [width-1:0] q;
    logic [width-1:0] acc;
    logic [width-1:0] acc_step;
    logic [width-1:0] q_step;
    logic            accept;
    logic            capture;
    logic            release_out;

    square_step #(.width(width)) u_step (
        .acc      (acc),
        .m        (m),
        .q        (q),
        .acc_next (acc_step),
        .q_next   (q_step)
    );

    // DONE spends its first cycle loading the result registers, then waits for out_ready.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!out_valid) begin
                    capture = 1'b1;
                end else if (out_ready) begin
                    release_out = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            p_hi      <= '0;
            p_lo      <= '0;
            count     <= '0;
            m         <= '0;
            q         <= '0;
            acc       <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == IDLE);
            if (accept) begin
                m     <= a;
                q     <= a;
                acc   <= '0;
                count <= '0;
            end else if (state == BUSY) begin
                acc   <= acc_step;
                q     <= q_step;
                count <= count + 1'b1;
            end
            if (capture) begin
                p_hi      <= acc;
                p_lo      <= q;
                out_valid <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_square_seq.sv
// tb/tb_square_seq.sv - directed self-checking bench for square_seq
module tb_square_seq;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] p_hi;
    logic [W-1:0] p_lo;

    int checks = 0;
    int errors = 0;

    square_seq #(.width(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_hi      (p_hi),
        .p_lo      (p_lo)
    );

    always #5 clock = ~clock;

    function automatic int isqrt(input longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return int'(r);
    endfunction

    // Runs one operand through; drives only, no comparisons.
    task automatic do_op(input logic [W-1:0] op, input int bp,
                         output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output int lat, output bit ok);
        int n;
        n   = 0;
        ok  = 1'b1;
        lat = 0;
        hi  = '0;
        lo  = '0;
        @(negedge clock);
        while (!in_ready && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            ok = 1'b0;
            return;
        end
        a        = op;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        a        = W'($urandom);
        while (!out_valid && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        if (!out_valid) begin
            ok = 1'b0;
            return;
        end
        hi = p_hi;
        lo = p_lo;
        repeat (bp) @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || p_hi !== '0 || p_lo !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b p_hi=%h p_lo=%h, want 0 0 0000 0000",
                     in_ready, out_valid, p_hi, p_lo);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_before_edge: got %b want 0", in_ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_after_release: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ops [5]  = '{16'h0000, 16'h00ff, 16'hffff, 16'h0100, 16'h016a};
        logic [W-1:0] ehi [5]  = '{16'h0000, 16'h0000, 16'hfffe, 16'h0001, 16'h0001};
        logic [W-1:0] elo [5]  = '{16'h0000, 16'hfe01, 16'h0001, 16'h0000, 16'hffe4};
        logic [W-1:0] hi, lo;
        int lat;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], i, hi, lo, lat, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL directed_timeout a=%h: no result within bound", ops[i]);
            end else if (hi !== ehi[i] || lo !== elo[i]) begin
                errors++;
                $display("FAIL directed a=%h: got %h_%h want %h_%h", ops[i], hi, lo, ehi[i], elo[i]);
            end
            checks++;
            if (lat !== W + 1) begin
                errors++;
                $display("FAIL latency a=%h: got %0d edges want %0d", ops[i], lat, W + 1);
            end
        end
    endtask

    task automatic test_hold();
        int n = 0;
        @(negedge clock);
        a        = 16'h00ff;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        while (!out_valid && n < 60) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 16'h1111;
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || p_hi !== 16'h0000 || p_lo !== 16'hfe01 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: out_valid=%b in_ready=%b p=%h_%h want 1 0 0000_fe01",
                         i, out_valid, in_ready, p_hi, p_lo);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || p_lo !== 16'hfe01) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b p_lo=%h want 0 1 fe01",
                     out_valid, in_ready, p_lo);
        end
        repeat (25) @(negedge clock);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || p_lo !== 16'hfe01) begin
            errors++;
            $display("FAIL idle_ignore: out_valid=%b in_ready=%b p_lo=%h want 0 1 fe01",
                     out_valid, in_ready, p_lo);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] hi, lo;
        int lat;
        bit ok;
        @(negedge clock);
        a        = 16'hffff;
        in_valid = 1'b1;
        @(posedge clock);
        repeat (8) @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || p_hi !== '0 || p_lo !== '0) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b p=%h_%h want 0 0 0000_0000",
                     out_valid, in_ready, p_hi, p_lo);
        end
        @(negedge clock);
        reset = 1'b0;
        do_op(16'h1234, 2, hi, lo, lat, ok);
        checks++;
        if (!ok || hi !== 16'h014b || lo !== 16'h5a90) begin
            errors++;
            $display("FAIL after_reset a=1234: ok=%b got %h_%h want 014b_5a90", ok, hi, lo);
        end
    endtask

    task automatic test_sweep();
        logic [W-1:0] hi, lo, op;
        logic [2*W-1:0] exp;
        int lat;
        bit ok;
        for (int i = 0; i < 120; i++) begin
            op  = (i < 4) ? W'(16'hfffc + i) : W'($urandom);
            exp = 32'(op) * 32'(op);
            do_op(op, int'($urandom_range(0, 3)), hi, lo, lat, ok);
            checks++;
            if (!ok || {hi, lo} !== exp) begin
                errors++;
                $display("FAIL sweep a=%h: ok=%b got %h_%h want %h", op, ok, hi, lo, exp);
            end
        end
    endtask

    task automatic test_fsqrt();
        int ns [9] = '{1, 2, 3, 5, 10, 99, 100, 200, 255};
        logic [W-1:0] hi, lo, op;
        int lat;
        bit ok;
        for (int i = 0; i < 9; i++) begin
            op = W'(isqrt(longint'(ns[i]) <<< 16));
            do_op(op, 1, hi, lo, lat, ok);
            checks++;
            if (!ok || int'(hi) > ns[i] || {hi, lo} !== 32'(op) * 32'(op)) begin
                errors++;
                $display("FAIL fsqrt n=%0d a=%h: ok=%b got %h_%h want hi<=%0d and %h",
                         ns[i], op, ok, hi, lo, ns[i], 32'(op) * 32'(op));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_sweep();
        test_fsqrt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
